// File: rtl/ofdm_pkg.sv
// Shared OFDM constants for the block interleaver: mode encodings, block sizes
// and the forward two-step permutation index (elaboration-time use only).
package ofdm_pkg;

   localparam logic [1:0] MODE_BPSK  = 2'd0;
   localparam logic [1:0] MODE_QPSK  = 2'd1;
   localparam logic [1:0] MODE_16QAM = 2'd2;
   localparam logic [1:0] MODE_64QAM = 2'd3;

   function automatic int ncbps(input int m);
      case (m)
         0:       return 48;
         1:       return 96;
         2:       return 192;
         default: return 288;
      endcase
   endfunction

   function automatic int nbpsc(input int m);
      case (m)
         0:       return 1;
         1:       return 2;
         2:       return 4;
         default: return 6;
      endcase
   endfunction

   // Stream index k -> output position j; divisions only ever see constants.
   function automatic int perm_idx(input int m, input int k);
      int n, s, i;
      n = ncbps(m);
      s = (nbpsc(m) / 2 < 1) ? 1 : nbpsc(m) / 2;
      i = (n / 16) * (k % 16) + k / 16;
      return s * (i / s) + (i + n - (16 * i) / n) % s;
   endfunction

endpackage

// File: rtl/interleaver_perm.sv
// Combinational bit permutation: four hard-wired interleaver maps, one per mode,
// selected by the bank's latched mode. Positions beyond the block size read 0.
module interleaver_perm
   import ofdm_pkg::*;
#(
   parameter int MAX_CBPS = 288
) (
   input  logic [MAX_CBPS-1:0] bank,
   input  logic [1:0]          mode,
   output logic [MAX_CBPS-1:0] out_data
);

   // Inverse map found by search so each output bit is a single wire.
   function automatic int inv_idx(input int m, input int j);
      int r;
      r = 0;
      for (int k = 0; k < ncbps(m); k++)
         if (perm_idx(m, k) == j) r = k;
      return r;
   endfunction

   logic [3:0][MAX_CBPS-1:0] pm;

   for (genvar m = 0; m < 4; m++) begin : g_mode
      for (genvar j = 0; j < MAX_CBPS; j++) begin : g_bit
         if (j < ncbps(m)) begin : g_on
            assign pm[m][j] = bank[inv_idx(m, j)];
         end else begin : g_off
            assign pm[m][j] = 1'b0;
         end
      end
   end

   assign out_data = pm[mode];

endmodule

// File: rtl/interleaver_multi.sv
// Multi-mode OFDM block interleaver: two ping-pong banks, one filling from the
// beat stream while the other presents its permuted block until consumed.
module interleaver_multi
   import ofdm_pkg::*;
#(
   parameter int IN_W     = 2,
   parameter int MAX_CBPS = 288
) (
   input  logic                Clk,
   input  logic                Rst_n,
   input  logic                en,
   input  logic [1:0]          mode,
   input  logic [IN_W-1:0]     in_data,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [MAX_CBPS-1:0] out_data,
   output logic [8:0]          out_len,
   output logic                ready,
   input  logic                out_ready
);

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_FILL  = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;

   logic [1:0]          st    [2];
   logic [1:0]          bmode [2];
   logic [MAX_CBPS-1:0] bank  [2];
   logic [8:0]          wcnt;
   logic                fptr, pptr;
   logic                acc, cons, last;
   logic [1:0]          fmode;
   logic [MAX_CBPS-1:0] perm_out;

   assign in_ready = Rst_n && (st[fptr] != ST_FULL);
   assign ready    = (st[pptr] == ST_FULL);
   assign acc      = en & in_valid & in_ready;
   assign cons     = en & ready & out_ready;
   // Mode is sampled live only on the first beat; afterwards the bank's copy rules.
   assign fmode    = (wcnt == 9'd0) ? mode : bmode[fptr];
   assign last     = (int'(wcnt) + IN_W) == ncbps(int'(fmode));

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         st[0]    <= ST_EMPTY;
         st[1]    <= ST_EMPTY;
         bmode[0] <= MODE_BPSK;
         bmode[1] <= MODE_BPSK;
         bank[0]  <= '0;
         bank[1]  <= '0;
         wcnt     <= '0;
         fptr     <= 1'b0;
         pptr     <= 1'b0;
      end else begin
         if (acc) begin
            for (int b = 0; b < IN_W; b++)
               bank[fptr][wcnt + 9'(b)] <= in_data[b];
            bmode[fptr] <= fmode;
            if (last) begin
               st[fptr] <= ST_FULL;
               fptr     <= ~fptr;
               wcnt     <= '0;
            end else begin
               st[fptr] <= ST_FILL;
               wcnt     <= wcnt + 9'(IN_W);
            end
         end
         // A presented bank is FULL and the fill bank never is, so these never collide.
         if (cons) begin
            st[pptr] <= ST_EMPTY;
            pptr     <= ~pptr;
         end
      end
   end

   interleaver_perm #(.MAX_CBPS(MAX_CBPS)) u_perm (
      .bank     (bank[pptr]),
      .mode     (bmode[pptr]),
      .out_data (perm_out)
   );

   assign out_data = ready ? perm_out : '0;
   assign out_len  = ready ? 9'(ncbps(int'(bmode[pptr]))) : 9'd0;

endmodule

// File: tb/tb_interleaver_multi.sv
// Directed bench for interleaver_multi with IN_W=2: hand-computed single-bit
// maps per mode, backpressure ordering, mid-block mode change, reset and enable.
module tb_interleaver_multi;

   logic         Clk, Rst_n, en, in_valid, in_ready, ready, out_ready;
   logic [1:0]   mode, in_data;
   logic [287:0] out_data;
   logic [8:0]   out_len;

   int nvec = 0;
   int nerr = 0;

   interleaver_multi #(.IN_W(2), .MAX_CBPS(288)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .en(en), .mode(mode), .in_data(in_data),
      .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
      .out_len(out_len), .ready(ready), .out_ready(out_ready)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [287:0] got, input logic [287:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Straight evaluation of the interleaver formula, forward direction.
   function automatic logic [287:0] ref_il(input int m, input logic [287:0] s);
      logic [287:0] r;
      int n, sp, i, j;
      r  = '0;
      n  = (m == 0) ? 48 : (m == 1) ? 96 : (m == 2) ? 192 : 288;
      sp = (m == 0) ? 1 : (m == 1) ? 1 : (m == 2) ? 2 : 3;
      for (int k = 0; k < n; k++) begin
         i = (n / 16) * (k % 16) + k / 16;
         j = sp * (i / sp) + (i + n - (16 * i) / n) % sp;
         r[j] = s[k];
      end
      return r;
   endfunction

   function automatic logic [287:0] rnd_stream();
      logic [287:0] s;
      for (int w = 0; w < 9; w++) s[w*32 +: 32] = $urandom;
      return s;
   endfunction

   // Called at a negedge; returns at the negedge after the beat is taken.
   task automatic put(input logic [1:0] d);
      int t;
      t = 0;
      in_data  = d;
      in_valid = 1'b1;
      while (!(in_ready && en) && t < 500) begin
         @(negedge Clk);
         t++;
      end
      if (t >= 500) chk("put_timeout", 1, 0);
      @(negedge Clk);
      in_valid = 1'b0;
   endtask

   task automatic send(input logic [1:0] m, input logic [287:0] s, input int first, input int stop);
      mode = m;
      for (int n = first; n < stop; n++) put(s[n*2 +: 2]);
   endtask

   task automatic take(input string tag, input logic [287:0] exp, input logic [8:0] len);
      int t;
      t = 0;
      while (!ready && t < 500) begin
         @(negedge Clk);
         t++;
      end
      chk({tag, "_rdy"}, 288'(ready), 288'(1));
      chk({tag, "_len"}, 288'(out_len), 288'(len));
      chk({tag, "_dat"}, out_data, exp);
      out_ready = 1'b1;
      @(negedge Clk);
      out_ready = 1'b0;
   endtask

   logic [287:0] sa, sb, sc, sd;

   initial begin
      Rst_n = 1'b0; en = 1'b1; mode = 2'd1; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
      repeat (3) @(negedge Clk);
      chk("rst_in_ready", 288'(in_ready), 288'(0));
      chk("rst_ready", 288'(ready), 288'(0));
      chk("rst_len", 288'(out_len), 288'(0));
      chk("rst_data", out_data, '0);
      Rst_n = 1'b1;
      @(negedge Clk);
      chk("rel_in_ready", 288'(in_ready), 288'(1));

      // QPSK, only k=1: ready right after the last beat, bit 6
      send(2'd1, 288'(2), 0, 48);
      chk("qpsk_latency", 288'(ready), 288'(1));
      take("qpsk_k1", 288'(1) << 6, 9'd96);
      send(2'd0, 288'(1) << 17, 0, 24);
      take("bpsk_k17", 288'(1) << 4, 9'd48);
      send(2'd2, 288'(2), 0, 96);
      take("qam16_k1", 288'(1) << 13, 9'd192);
      send(2'd3, 288'(2), 0, 144);
      take("qam64_k1", 288'(1) << 20, 9'd288);

      // Backpressure: two blocks fill both banks, third waits
      sa = rnd_stream(); sb = rnd_stream(); sc = rnd_stream();
      send(2'd1, sa, 0, 48);
      send(2'd1, sb, 0, 48);
      chk("bp_in_ready", 288'(in_ready), 288'(0));
      chk("bp_hold0", out_data, ref_il(1, sa));
      repeat (5) @(negedge Clk);
      chk("bp_hold5", out_data, ref_il(1, sa));
      fork
         send(2'd1, sc, 0, 48);
         begin
            take("bp_blk1", ref_il(1, sa), 9'd96);
            take("bp_blk2", ref_il(1, sb), 9'd96);
            take("bp_blk3", ref_il(1, sc), 9'd96);
         end
      join

      // Mode changes after the first beat are ignored
      sd = rnd_stream();
      send(2'd0, sd, 0, 1);
      send(2'd1, sd, 1, 24);
      take("mode_latch", ref_il(0, sd), 9'd48);

      // Reset mid-block discards the partial block
      send(2'd1, {288{1'b1}}, 0, 20);
      Rst_n = 1'b0;
      #1;
      chk("mid_rst_ready", 288'(ready), 288'(0));
      chk("mid_rst_in_ready", 288'(in_ready), 288'(0));
      @(negedge Clk);
      Rst_n = 1'b1;
      @(negedge Clk);
      chk("mid_rel_in_ready", 288'(in_ready), 288'(1));
      sd = rnd_stream();
      send(2'd1, sd, 0, 48);
      take("post_rst", ref_il(1, sd), 9'd96);

      // Enable low with junk valid beats must not disturb the block
      sd = rnd_stream();
      send(2'd1, sd, 0, 20);
      en = 1'b0; in_valid = 1'b1; in_data = ~sd[40 +: 2];
      repeat (10) @(negedge Clk);
      in_valid = 1'b0; en = 1'b1;
      chk("en_off_ready", 288'(ready), 288'(0));
      send(2'd1, sd, 20, 48);
      take("en_gap", ref_il(1, sd), 9'd96);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
